equiv_sequencer: RTL

Sequences a bank of stimulus vectors through two combinational netlists sharing one input bus: the original design and its instruction-reduced rewrite. Each vector is applied, allowed to settle, and both netlists' outputs are compared. The block logs the optimized output per vector and counts mismatches. It replaces the one-shot read/display/write testbench flow with a clocked, self-checking equivalence harness that sits between the vector loader and the two netlists.

---
 rtl/equiv_sequencer_if.sv | 39 +++
 rtl/equiv_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/equiv_sequencer_if.sv
// Bus between the vector loader / netlist pair and the equivalence sequencer.
// master = loader and netlist side, slave = sequencer.
interface equiv_sequencer_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 10,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             vec_wr_en;
    logic [AW-1:0]    vec_wr_addr;
    logic [IN_W-1:0]  vec_wr_data;
    logic [AW:0]      num_vec;
    logic             start;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] ref_out;
    logic [OUT_W-1:0] opt_out;
    logic             busy;
    logic             done;
    logic [AW:0]      mismatch_cnt;
    logic             fail_valid;
    logic [AW-1:0]    fail_idx;
    logic [AW-1:0]    res_rd_addr;
    logic [OUT_W-1:0] res_rd_data;

    modport master (
        output vec_wr_en, vec_wr_addr, vec_wr_data, num_vec, start,
               ref_out, opt_out, res_rd_addr,
        input  dut_in, busy, done, mismatch_cnt, fail_valid, fail_idx,
               res_rd_data
    );

    modport slave (
        input  vec_wr_en, vec_wr_addr, vec_wr_data, num_vec, start,
               ref_out, opt_out, res_rd_addr,
        output dut_in, busy, done, mismatch_cnt, fail_valid, fail_idx,
               res_rd_data
    );
endinterface

// File: rtl/equiv_sequencer.sv
// Clocked equivalence harness: drives stored vectors into the original and
// optimized netlists, logs the optimized output and counts disagreements.
//
// state   | meaning
// IDLE    | waiting for start; vector memory writable
// APPLY   | register vmem[idx] onto dut_in
// WAIT    | let the netlists settle for SETTLE cycles
// CHECK   | log opt_out, compare against ref_out, advance idx
// DONE    | one-cycle done pulse, then back to IDLE
module equiv_sequencer #(
    parameter int IN_W   = 20,
    parameter int OUT_W  = 10,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    equiv_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    idx_q;
    logic [AW:0]      n_q;
    logic [WW-1:0]    wcnt_q;
    logic [IN_W-1:0]  dut_in_q;
    logic             busy_q;
    logic             done_q;
    logic [AW:0]      mismatch_cnt_q;
    logic             fail_valid_q;
    logic [AW-1:0]    fail_idx_q;

    logic [IN_W-1:0]  vmem [DEPTH];
    logic [OUT_W-1:0] rmem [DEPTH];

    logic [AW:0]      n_d;
    logic             last_d;
    logic             diff_d;

    always_comb begin
        n_d    = (bus.num_vec > DEPTH_W) ? DEPTH_W : bus.num_vec;
        last_d = ({1'b0, idx_q} == (n_q - 1'b1));
        diff_d = (bus.ref_out != bus.opt_out);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            n_q            <= '0;
            wcnt_q         <= '0;
            dut_in_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mismatch_cnt_q <= '0;
            fail_valid_q   <= 1'b0;
            fail_idx_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        n_q            <= n_d;
                        idx_q          <= '0;
                        mismatch_cnt_q <= '0;
                        fail_valid_q   <= 1'b0;
                        fail_idx_q     <= '0;
                        busy_q         <= 1'b1;
                        if (n_d != '0) begin
                            state_q <= S_APPLY;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_APPLY: begin
                    dut_in_q <= vmem[idx_q];
                    if (SETTLE > 0) begin
                        wcnt_q  <= WW'(SETTLE);
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == WW'(1)) state_q <= S_CHECK;
                    else                  wcnt_q  <= wcnt_q - 1'b1;
                end
                S_CHECK: begin
                    if (diff_d) begin
                        mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_idx_q   <= idx_q;
                        end
                    end
                    if (last_d) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_APPLY;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Loader writes only land while idle, so a running bank is never disturbed.
    always_ff @(posedge clk) begin
        if (bus.vec_wr_en && !busy_q) vmem[bus.vec_wr_addr] <= bus.vec_wr_data;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CHECK) rmem[idx_q] <= bus.opt_out;
    end

    assign bus.dut_in       = dut_in_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mismatch_cnt = mismatch_cnt_q;
    assign bus.fail_valid   = fail_valid_q;
    assign bus.fail_idx     = fail_idx_q;
    assign bus.res_rd_data  = rmem[bus.res_rd_addr];
endmodule
